// File: rtl/mux_sel_pipe.sv
// mux_sel_pipe: registered N:1 channel selector with manual/scan capture.
// Optional MUX_SEL_ERR_CNT_EN builds the saturating out-of-range counter.
//
// Ports:
//   CLK, RST_N                 clock, async active-low reset
//   inp_flat                   channel k at [k*WIDTH +: WIDTH]
//   sel_in/req_valid/req_ready manual select request handshake
//   scan_en                    auto-scan enable (overrides manual)
//   out/out_sel/sel_err        registered selection result
//   out_valid/out_ready        output handshake
//   err_cnt                    out-of-range capture count (0 if disabled)
module mux_sel_pipe #(
    parameter int NUM_INP = 31,
    parameter int WIDTH   = 2,
    parameter int SEL_W   = 5
) (
    input  logic                     CLK,
    input  logic                     RST_N,
    input  logic [NUM_INP*WIDTH-1:0] inp_flat,
    input  logic [SEL_W-1:0]         sel_in,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     scan_en,
    output logic [WIDTH-1:0]         out,
    output logic [SEL_W-1:0]         out_sel,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     sel_err,
    output logic [7:0]               err_cnt
);

    typedef enum logic [1:0] {
        IDLE,
        MANUAL,
        SCAN
    } state_t;

    state_t state_q, state_d;

    logic [SEL_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic [SEL_W-1:0] out_sel_q, out_sel_d;
    logic             out_valid_q, out_valid_d;
    logic             sel_err_q, sel_err_d;

    logic             slot_free;
    logic             cap;
    logic [SEL_W-1:0] idx;
    logic [WIDTH-1:0] sel_data;
    logic             idx_err;

    // Control: IDLE only decodes, so it accepts requests just like MANUAL.
    always_comb begin
        slot_free = !out_valid_q || out_ready;
        state_d   = state_q;
        cnt_d     = cnt_q;
        req_ready = 1'b0;
        cap       = 1'b0;
        idx       = sel_in;
        unique case (state_q)
            IDLE: begin
                req_ready = slot_free && !scan_en;
                cap       = req_valid && req_ready;
                if (scan_en)        state_d = SCAN;
                else if (req_valid) state_d = MANUAL;
            end
            MANUAL: begin
                req_ready = slot_free && !scan_en;
                cap       = req_valid && req_ready;
                if (scan_en)         state_d = SCAN;
                else if (!req_valid) state_d = IDLE;
            end
            SCAN: begin
                if (scan_en) begin
                    idx = cnt_q;
                    cap = slot_free;
                    if (cap) begin
                        if (cnt_q == SEL_W'(NUM_INP - 1)) cnt_d = '0;
                        else                              cnt_d = cnt_q + 1'b1;
                    end
                end else begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Channel mux; only legal indices are decoded, others give zero.
    always_comb begin
        sel_data = '0;
        for (int k = 0; k < NUM_INP; k++) begin
            if (idx == SEL_W'(k)) sel_data = inp_flat[k*WIDTH +: WIDTH];
        end
        idx_err = (32'(idx) >= 32'(NUM_INP));
    end

    always_comb begin
        out_d       = out_q;
        out_sel_d   = out_sel_q;
        sel_err_d   = sel_err_q;
        out_valid_d = out_valid_q;
        if (cap) begin
            out_d       = idx_err ? '0 : sel_data;
            out_sel_d   = idx;
            sel_err_d   = idx_err;
            out_valid_d = 1'b1;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            out_q       <= '0;
            out_sel_q   <= '0;
            sel_err_q   <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            out_q       <= out_d;
            out_sel_q   <= out_sel_d;
            sel_err_q   <= sel_err_d;
            out_valid_q <= out_valid_d;
        end
    end

`ifdef MUX_SEL_ERR_CNT_EN
    logic [7:0] err_cnt_q, err_cnt_d;

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (cap && idx_err && err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) err_cnt_q <= '0;
        else        err_cnt_q <= err_cnt_d;
    end

    assign err_cnt = err_cnt_q;
`else
    assign err_cnt = 8'd0;
`endif

    assign out       = out_q;
    assign out_sel   = out_sel_q;
    assign sel_err   = sel_err_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_mux_sel_pipe.sv
// tb_mux_sel_pipe: directed table plus hand sequences for mux_sel_pipe.
// Expected values are hand-computed from the channel pattern k[1:0].
module tb_mux_sel_pipe;

    localparam int N  = 31;
    localparam int W  = 2;
    localparam int SW = 5;

    logic          CLK;
    logic          RST_N;
    logic [N*W-1:0] inp_flat;
    logic [SW-1:0] sel_in;
    logic          req_valid;
    logic          req_ready;
    logic          scan_en;
    logic [W-1:0]  out;
    logic [SW-1:0] out_sel;
    logic          out_valid;
    logic          out_ready;
    logic          sel_err;
    logic [7:0]    err_cnt;

    int checks;
    int errors;
    int ecnt;

    mux_sel_pipe #(.NUM_INP(N), .WIDTH(W), .SEL_W(SW)) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .inp_flat  (inp_flat),
        .sel_in    (sel_in),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .scan_en   (scan_en),
        .out       (out),
        .out_sel   (out_sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sel_err   (sel_err),
        .err_cnt   (err_cnt)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [SW-1:0] sel;
        logic          rv;
        logic          ordy;
        logic          exp_rr;
        logic [W-1:0]  exp_out;
        logic [SW-1:0] exp_sel;
        logic          exp_v;
        logic          exp_err;
        logic          cap;
    } vec_t;

    vec_t tbl[8];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [31:0] exp_ecnt();
`ifdef MUX_SEL_ERR_CNT_EN
        return (ecnt > 255) ? 32'd255 : 32'(ecnt);
`else
        return 32'd0;
`endif
    endfunction

    task automatic set_inp(input bit inv);
        for (int k = 0; k < N; k++) begin
            logic [W-1:0] v;
            v = W'(k);
            inp_flat[k*W +: W] = inv ? ~v : v;
        end
    endtask

    task automatic chk_out(input string name, input logic [W-1:0] eo,
                           input logic [SW-1:0] es, input logic ev,
                           input logic ee);
        chk({name, ".out"}, 32'(out), 32'(eo));
        chk({name, ".out_sel"}, 32'(out_sel), 32'(es));
        chk({name, ".out_valid"}, 32'(out_valid), 32'(ev));
        chk({name, ".sel_err"}, 32'(sel_err), 32'(ee));
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        ecnt      = 0;
        RST_N     = 1'b0;
        sel_in    = '0;
        req_valid = 1'b0;
        scan_en   = 1'b0;
        out_ready = 1'b1;
        set_inp(1'b0);

        //           sel rv or rr out sel  v  e cap
        tbl[0] = '{5'd5,  1, 1, 1, 2'd1, 5'd5,  1, 0, 1};
        tbl[1] = '{5'd31, 1, 1, 1, 2'd0, 5'd31, 1, 1, 1};
        tbl[2] = '{5'd30, 1, 1, 1, 2'd2, 5'd30, 1, 0, 1};
        tbl[3] = '{5'd7,  1, 1, 1, 2'd3, 5'd7,  1, 0, 1};
        tbl[4] = '{5'd7,  0, 1, 1, 2'd3, 5'd7,  0, 0, 0};
        tbl[5] = '{5'd0,  1, 1, 1, 2'd0, 5'd0,  1, 0, 1};
        tbl[6] = '{5'd2,  1, 0, 0, 2'd0, 5'd0,  1, 0, 0};
        tbl[7] = '{5'd2,  1, 1, 1, 2'd2, 5'd2,  1, 0, 1};

        #3;
        chk_out("reset", 2'd0, 5'd0, 1'b0, 1'b0);
        chk("reset.err_cnt", 32'(err_cnt), 32'd0);
        repeat (2) @(posedge CLK);
        #2;
        RST_N = 1'b1;

        for (int i = 0; i < 8; i++) begin
            sel_in    = tbl[i].sel;
            req_valid = tbl[i].rv;
            out_ready = tbl[i].ordy;
            #1;
            chk($sformatf("vec%0d.req_ready", i), 32'(req_ready),
                32'(tbl[i].exp_rr));
            step();
            chk_out($sformatf("vec%0d", i), tbl[i].exp_out, tbl[i].exp_sel,
                    tbl[i].exp_v, tbl[i].exp_err);
            if (tbl[i].cap && tbl[i].exp_err) ecnt++;
            chk($sformatf("vec%0d.err_cnt", i), 32'(err_cnt), exp_ecnt());
        end

        // Stall: data holds while consumer is not ready.
        sel_in = 5'd9; req_valid = 1'b1; out_ready = 1'b1;
        step();
        chk_out("stall.load", 2'd1, 5'd9, 1'b1, 1'b0);
        sel_in = 5'd4; out_ready = 1'b0;
        set_inp(1'b1);
        #1;
        chk("stall.req_ready", 32'(req_ready), 32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk_out($sformatf("stall.hold%0d", i), 2'd1, 5'd9, 1'b1, 1'b0);
            chk("stall.hold_rr", 32'(req_ready), 32'd0);
        end
        out_ready = 1'b1;
        #1;
        chk("stall.release_rr", 32'(req_ready), 32'd1);
        step();
        chk_out("stall.new", 2'd3, 5'd4, 1'b1, 1'b0);
        set_inp(1'b0);

        // Error saturation.
        sel_in = 5'd31;
        for (int i = 0; i < 300; i++) begin
            step();
            ecnt++;
        end
        chk_out("sat", 2'd0, 5'd31, 1'b1, 1'b1);
        chk("sat.err_cnt", 32'(err_cnt), exp_ecnt());

        // Scan wins over a simultaneous manual request.
        sel_in = 5'd3; scan_en = 1'b1;
        #1;
        chk("scan.req_ready", 32'(req_ready), 32'd0);
        step();
        chk("scan.enter_valid", 32'(out_valid), 32'd0);
        for (int i = 0; i < 33; i++) begin
            step();
            chk_out($sformatf("scan%0d", i), W'(i % N), SW'(i % N),
                    1'b1, 1'b0);
            chk("scan.rr", 32'(req_ready), 32'd0);
        end
        scan_en = 1'b0; req_valid = 1'b0;
        step();
        chk_out("scan.exit", 2'd1, 5'd1, 1'b0, 1'b0);
        req_valid = 1'b1;
        #1;
        chk("manual3.req_ready", 32'(req_ready), 32'd1);
        step();
        chk_out("manual3", 2'd3, 5'd3, 1'b1, 1'b0);
        req_valid = 1'b0;
        step();

        // Asynchronous reset in the middle of a scan.
        scan_en = 1'b1;
        repeat (4) step();
        chk_out("midscan", 2'd2, 5'd2, 1'b1, 1'b0);
        #3;
        RST_N = 1'b0;
        #1;
        chk_out("async_rst", 2'd0, 5'd0, 1'b0, 1'b0);
        chk("async_rst.err_cnt", 32'(err_cnt), 32'd0);
        @(posedge CLK);
        #2;
        RST_N = 1'b1;
        step();
        chk("restart.enter", 32'(out_valid), 32'd0);
        step();
        chk_out("restart", 2'd0, 5'd0, 1'b1, 1'b0);
        step();
        chk_out("restart1", 2'd1, 5'd1, 1'b1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
